// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    // Offset from the start-bit edge to its centre, in clocks.
    function automatic int half_bit(input int clk_per_bit);
        return (clk_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
module sync_2ff #(
    parameter logic rst_val = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_D,
    output logic o_Q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_meta <= rst_val;
            r_sync <= rst_val;
        end else begin
            r_meta <= i_D;
            r_sync <= r_meta;
        end
    end

    assign o_Q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the line with i_Clock and strobes o_Rx_DV
// for one cycle per good frame, with the byte held in o_Rx_Byte.
//
// state   | meaning
// IDLE    | line idle, waiting for rx_s low
// START   | timing to the start-bit centre; high there means a glitch
// DATA    | sampling 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit; high publishes the byte
// CLEANUP | one-cycle gap before IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_per_bit = 87
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int HALF = half_bit(clk_per_bit);
    localparam int CW   = $clog2(clk_per_bit) + 1;

    localparam logic [CW-1:0]    C_HALF     = CW'(HALF);
    localparam logic [CW-1:0]    C_LAST     = CW'(clk_per_bit - 1);
    localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic w_rx_s;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_dv;
    logic [DATA_BITS-1:0]   r_byte;

    state_t                 w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_dv_nxt;
    logic [DATA_BITS-1:0]   w_byte_nxt;

    sync_2ff #(
        .rst_val (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_D     (i_Rx_Serial),
        .o_Q     (w_rx_s)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dv    <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_dv    <= w_dv_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // The strobe defaults low, so it can only ever last the one cycle after STOP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_dv_nxt    = 1'b0;
        w_byte_nxt  = r_byte;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == C_LAST_BIT) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = CLEANUP;
                    if (w_rx_s) begin
                        w_dv_nxt   = 1'b1;
                        w_byte_nxt = r_shift;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CLEANUP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_Rx_DV   = r_dv;
        o_Rx_Byte = r_byte;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at three bit periods against a frame-level scoreboard model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int NCH = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   rx_line = '1;
    logic [NCH-1:0]   dv;
    logic [7:0]       rbyte [NCH];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         exp_cyc  [NCH][16];
    logic [7:0] exp_byte [NCH][16];
    int         head [NCH] = '{default: 0};
    int         tail [NCH] = '{default: 0};
    logic [7:0] last_byte [NCH] = '{default: 8'h00};
    logic       prev_dv [NCH] = '{default: 1'b0};
    int         dv_n [NCH] = '{default: 0};
    int         dv_log_cyc  [NCH][64];
    logic [7:0] dv_log_byte [NCH][64];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCH; g++) begin : g_dut
        localparam int P = (g == 0) ? 87 : ((g == 1) ? 16 : 4);
        uart_rx #(.clk_per_bit(P)) u_dut (
            .i_Clock     (clk),
            .i_Reset     (rst),
            .i_Rx_Serial (rx_line[g]),
            .o_Rx_DV     (dv[g]),
            .o_Rx_Byte   (rbyte[g])
        );
    end

    function automatic int cpb_of(input int ch);
        case (ch)
            0:       return 87;
            1:       return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int half_of(input int ch);
        return (cpb_of(ch) - 1) / 2;
    endfunction

    task automatic check(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", name, got, got, exp_v, exp_v);
        end
    endtask

    task automatic check_near(input string name, input int got, input int exp_v, input int tol);
        checks++;
        if (got < exp_v - tol || got > exp_v + tol) begin
            errors++;
            $display("FAIL %s got %0d exp %0d +/-%0d", name, got, exp_v, tol);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard: each good frame predicts one strobe at start + 3 + HALF + 9*bit.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (rst) begin
                    check($sformatf("rst_dv_ch%0d", c), int'(dv[c]), 0);
                    check($sformatf("rst_byte_ch%0d", c), int'(rbyte[c]), 0);
                    head[c]      = tail[c];
                    last_byte[c] = 8'h00;
                end else if (dv[c]) begin
                    check($sformatf("dv_width_ch%0d", c), int'(prev_dv[c]), 0);
                    if (dv_n[c] < 64) begin
                        dv_log_cyc[c][dv_n[c]]  = cyc;
                        dv_log_byte[c][dv_n[c]] = rbyte[c];
                    end
                    dv_n[c]++;
                    checks++;
                    if (head[c] == tail[c]) begin
                        errors++;
                        $display("FAIL spurious_dv_ch%0d got byte 0x%0h at cycle %0d exp no strobe", c, rbyte[c], cyc);
                    end else begin
                        check_near($sformatf("dv_time_ch%0d", c), cyc, exp_cyc[c][head[c] % 16], 1);
                        check($sformatf("dv_byte_ch%0d", c), int'(rbyte[c]), int'(exp_byte[c][head[c] % 16]));
                        last_byte[c] = exp_byte[c][head[c] % 16];
                        head[c]++;
                    end
                end else begin
                    check($sformatf("byte_hold_ch%0d", c), int'(rbyte[c]), int'(last_byte[c]));
                    if (head[c] != tail[c] && cyc > exp_cyc[c][head[c] % 16] + 1) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_dv_ch%0d got no strobe by cycle %0d exp one at %0d", c, cyc, exp_cyc[c][head[c] % 16]);
                        head[c]++;
                    end
                end
                prev_dv[c] = dv[c];
            end
        end
    end

    task automatic send_frame(input int ch, input logic [7:0] b, input logic stop, input int gap);
        int p;
        logic [9:0] bits;
        p    = cpb_of(ch);
        bits = {stop, b, 1'b0};
        if (stop) begin
            exp_cyc[ch][tail[ch] % 16]  = cyc + 1 + 3 + half_of(ch) + 9 * p;
            exp_byte[ch][tail[ch] % 16] = b;
            tail[ch]++;
        end
        for (int i = 0; i < 10; i++) begin
            rx_line[ch] = bits[i];
            tick(p);
        end
        rx_line[ch] = 1'b1;
        tick(gap);
        if (!stop) tick(2 * p + 4);
    endtask

    task automatic send_glitch(input int ch, input int len);
        rx_line[ch] = 1'b0;
        tick(len);
        rx_line[ch] = 1'b1;
        tick(half_of(ch) + cpb_of(ch) + 4);
    endtask

    initial begin
        int n;
        int c0;
        int ch;
        int kind;

        rst = 1'b1;
        rx_line = '1;
        tick(10);
        rst = 1'b0;
        tick(10);
        check("reset_byte", int'(rbyte[0]), 8'h00);
        check("reset_dv", int'(dv[0]), 0);

        // Reset mid-frame abandons it.
        rx_line[0] = 1'b0;
        tick(400);
        rst = 1'b1;
        tick(3);
        rx_line[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        n = dv_n[0];
        tick(2000);
        check("reset_midframe_no_dv", dv_n[0] - n, 0);
        check("reset_midframe_byte", int'(rbyte[0]), 8'h00);

        // Single frame: latency pinned to the hand-computed 829.
        n  = dv_n[0];
        c0 = cyc;
        send_frame(0, 8'hA5, 1'b1, 0);
        tick(100);
        check("a5_count", dv_n[0] - n, 1);
        check_near("a5_latency", dv_log_cyc[0][n] - (c0 + 1), 829, 1);
        check("a5_byte", int'(rbyte[0]), 8'hA5);

        // Back-to-back frames.
        n = dv_n[0];
        send_frame(0, 8'h00, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b1, 0);
        send_frame(0, 8'h3C, 1'b1, 0);
        tick(50);
        check("b2b_count", dv_n[0] - n, 3);
        check("b2b_byte0", int'(dv_log_byte[0][n]), 8'h00);
        check("b2b_byte1", int'(dv_log_byte[0][n + 1]), 8'hFF);
        check("b2b_byte2", int'(dv_log_byte[0][n + 2]), 8'h3C);
        check_near("b2b_gap01", dv_log_cyc[0][n + 1] - dv_log_cyc[0][n], 870, 1);
        check_near("b2b_gap12", dv_log_cyc[0][n + 2] - dv_log_cyc[0][n + 1], 870, 1);

        // Glitch rejection followed by a good frame.
        n = dv_n[0];
        send_glitch(0, 20);
        tick(200);
        check("glitch_no_dv", dv_n[0] - n, 0);
        send_frame(0, 8'h55, 1'b1, 20);
        check("glitch_then_55", int'(rbyte[0]), 8'h55);

        // Framing error keeps the previous byte.
        n = dv_n[0];
        send_frame(0, 8'h81, 1'b0, 0);
        check("framing_no_dv", dv_n[0] - n, 0);
        check("framing_byte_kept", int'(rbyte[0]), 8'h55);
        send_frame(0, 8'h7E, 1'b1, 20);
        check("framing_then_7e", int'(rbyte[0]), 8'h7E);

        // Short bit periods.
        for (int c = 1; c < NCH; c++) begin
            n = dv_n[c];
            send_frame(c, 8'h01, 1'b1, 0);
            send_frame(c, 8'h80, 1'b1, 0);
            tick(20);
            check($sformatf("sweep_count_ch%0d", c), dv_n[c] - n, 2);
            check($sformatf("sweep_b0_ch%0d", c), int'(dv_log_byte[c][n]), 8'h01);
            check($sformatf("sweep_b1_ch%0d", c), int'(dv_log_byte[c][n + 1]), 8'h80);
            check($sformatf("sweep_out_ch%0d", c), int'(rbyte[c]), 8'h80);
        end

        // Break: line held low never yields a strobe.
        n = dv_n[2];
        rx_line[2] = 1'b0;
        tick(300);
        check("break_no_dv", dv_n[2] - n, 0);
        check("break_byte_kept", int'(rbyte[2]), 8'h80);
        rst = 1'b1;
        tick(2);
        rx_line[2] = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);

        // Randomized traffic across all three bit periods.
        for (int i = 0; i < 30; i++) begin
            ch   = $urandom_range(0, NCH - 1);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send_glitch(ch, $urandom_range(1, half_of(ch)));
            end else if (kind == 1) begin
                send_frame(ch, 8'($urandom_range(0, 255)), 1'b0, 0);
            end else begin
                send_frame(ch, 8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, cpb_of(ch)));
            end
        end
        tick(100);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("final_drain_ch%0d", c), tail[c] - head[c], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
